// File: rtl/rs_pkg.sv
// Shared definitions for the Reed-Solomon syndrome path: GF(2^8) constants,
// the sequencer state encoding and the multiply-by-alpha helper.
package rs_pkg;

    localparam int GF_W = 8;
    localparam logic [GF_W-1:0] PRIM_POLY = 8'h1D;
    localparam int NSYN_MAX = 32;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_ROOTS = 3'd1,
        STREAM     = 3'd2,
        FLUSH      = 3'd3,
        COLLECT    = 3'd4,
        DONE       = 3'd5
    } state_t;

    // Multiply a field element by alpha (x) and reduce by the primitive polynomial.
    function automatic logic [GF_W-1:0] gf_xtime(input logic [GF_W-1:0] r,
                                                 input logic [GF_W-1:0] poly);
        return {r[GF_W-2:0], 1'b0} ^ (r[GF_W-1] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/rs_root_gen.sv
// Alpha-power generator: load restarts the sequence at SEED (alpha^1),
// each step advances to the next power of alpha. Shared with the Chien search.
module rs_root_gen
    import rs_pkg::*;
#(
    parameter logic [GF_W-1:0] POLY = PRIM_POLY,
    parameter logic [GF_W-1:0] SEED = 8'h02
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    output logic [GF_W-1:0] root
);

    // Hold the current alpha power; load has priority over step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            root <= 8'h00;
        end else if (load) begin
            root <= SEED;
        end else if (step) begin
            root <= gf_xtime(root, POLY);
        end else begin
            root <= root;
        end
    end

endmodule

// File: rtl/rs_syndrome_ctrl.sv
// Reed-Solomon syndrome sequencer: loads the generator roots once after reset,
// streams each codeword into the syndrome calculator, then forwards the
// syndromes downstream and flags any non-zero syndrome.
// Optional build macro RS_SYND_BYPASS_EN adds bypass_en, which skips the
// flush/collect phases for the frame it is sampled with.
module rs_syndrome_ctrl
    import rs_pkg::*;
#(
    parameter int              NSYN      = 32,
    parameter int              N_SYM     = 255,
    parameter logic [7:0]      PRIM_POLY = 8'h1D,
    parameter int              FLUSH_CYC = 2
) (
    input  logic       clock,
    input  logic       reset,
`ifdef RS_SYND_BYPASS_EN
    input  logic       bypass_en,
`endif
    input  logic       frame_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       synd_start,
    output logic [7:0] synd_addr,
    output logic [7:0] synd_root,
    output logic       synd_root_valid,
    output logic       synd_roots_done,
    output logic [7:0] synd_data,
    output logic       synd_new_data,
    output logic       synd_stop,
    input  logic [7:0] synd_in,
    input  logic       synd_in_valid,
    output logic [7:0] syn_out,
    output logic [5:0] syn_out_idx,
    output logic       syn_out_valid,
    output logic       error_detected,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [7:0] SYM_LAST   = 8'(N_SYM - 32'sd1);
    localparam logic [7:0] ADDR_LAST  = 8'(NSYN);
    localparam logic [5:0] IDX_LAST   = 6'(NSYN);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYC - 32'sd1);

    state_t     state_r;
    logic       roots_loaded_r;
    logic [7:0] sym_cnt_r;
    logic [7:0] flush_cnt_r;
    logic [5:0] idx_r;
    logic       err_acc_r;
    logic       root_load_s;
    logic       root_step_s;
    logic       bypass_s;

`ifdef RS_SYND_BYPASS_EN
    logic bypass_r;

    // Capture the bypass request for the whole frame when it starts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bypass_r <= 1'b0;
        end else if (state_r == IDLE && frame_start) begin
            bypass_r <= bypass_en;
        end else begin
            bypass_r <= bypass_r;
        end
    end

    assign bypass_s = bypass_r;
`else
    assign bypass_s = 1'b0;
`endif

    // Root generator control: seed on a frame that needs roots, advance while writing.
    always_comb begin
        root_load_s = 1'b0;
        root_step_s = 1'b0;
        if (state_r == IDLE && frame_start && !roots_loaded_r) begin
            root_load_s = 1'b1;
        end else begin
            root_load_s = 1'b0;
        end
        if (state_r == LOAD_ROOTS && synd_root_valid && synd_addr != ADDR_LAST) begin
            root_step_s = 1'b1;
        end else begin
            root_step_s = 1'b0;
        end
    end

    rs_root_gen #(
        .POLY (PRIM_POLY),
        .SEED (8'h02)
    ) u_root_gen (
        .clock (clock),
        .reset (reset),
        .load  (root_load_s),
        .step  (root_step_s),
        .root  (synd_root)
    );

    // Frame sequencer with all handshake and status outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r         <= IDLE;
            roots_loaded_r  <= 1'b0;
            sym_cnt_r       <= 8'd0;
            flush_cnt_r     <= 8'd0;
            idx_r           <= 6'd0;
            err_acc_r       <= 1'b0;
            in_ready        <= 1'b0;
            synd_start      <= 1'b0;
            synd_addr       <= 8'd0;
            synd_root_valid <= 1'b0;
            synd_roots_done <= 1'b0;
            synd_data       <= 8'd0;
            synd_new_data   <= 1'b0;
            synd_stop       <= 1'b0;
            syn_out         <= 8'd0;
            syn_out_idx     <= 6'd0;
            syn_out_valid   <= 1'b0;
            error_detected  <= 1'b0;
            frame_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to zero unless re-asserted below.
            synd_new_data   <= 1'b0;
            syn_out_valid   <= 1'b0;
            frame_done      <= 1'b0;
            synd_roots_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (frame_start) begin
                        err_acc_r      <= 1'b0;
                        error_detected <= 1'b0;
                        busy           <= 1'b1;
                        sym_cnt_r      <= 8'd0;
                        idx_r          <= 6'd1;
                        if (roots_loaded_r) begin
                            state_r  <= STREAM;
                            in_ready <= 1'b1;
                        end else begin
                            state_r         <= LOAD_ROOTS;
                            synd_start      <= 1'b1;
                            synd_root_valid <= 1'b1;
                            synd_addr       <= 8'd1;
                        end
                    end
                end
                LOAD_ROOTS: begin
                    if (synd_roots_done) begin
                        state_r    <= STREAM;
                        synd_start <= 1'b0;
                        in_ready   <= 1'b1;
                    end else if (synd_addr == ADDR_LAST) begin
                        synd_root_valid <= 1'b0;
                        synd_addr       <= 8'd0;
                        synd_roots_done <= 1'b1;
                        roots_loaded_r  <= 1'b1;
                    end else begin
                        synd_addr <= synd_addr + 8'd1;
                    end
                end
                STREAM: begin
                    if (in_valid && in_ready) begin
                        synd_data     <= in_data;
                        synd_new_data <= 1'b1;
                        if (sym_cnt_r == SYM_LAST) begin
                            in_ready  <= 1'b0;
                            sym_cnt_r <= 8'd0;
                            if (bypass_s) begin
                                state_r        <= DONE;
                                frame_done     <= 1'b1;
                                error_detected <= 1'b0;
                            end else begin
                                state_r     <= FLUSH;
                                flush_cnt_r <= 8'd0;
                            end
                        end else begin
                            sym_cnt_r <= sym_cnt_r + 8'd1;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r == FLUSH_LAST) begin
                        state_r   <= COLLECT;
                        synd_stop <= 1'b1;
                        idx_r     <= 6'd1;
                    end else begin
                        flush_cnt_r <= flush_cnt_r + 8'd1;
                    end
                end
                COLLECT: begin
                    if (synd_in_valid) begin
                        syn_out       <= synd_in;
                        syn_out_idx   <= idx_r;
                        syn_out_valid <= 1'b1;
                        err_acc_r     <= err_acc_r | (synd_in != 8'd0);
                        if (idx_r == IDX_LAST) begin
                            state_r        <= DONE;
                            synd_stop      <= 1'b0;
                            frame_done     <= 1'b1;
                            error_detected <= err_acc_r | (synd_in != 8'd0);
                        end else begin
                            idx_r <= idx_r + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r         <= IDLE;
                    busy            <= 1'b0;
                    in_ready        <= 1'b0;
                    synd_start      <= 1'b0;
                    synd_stop       <= 1'b0;
                    synd_root_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_ctrl.sv
// Directed self-checking bench for rs_syndrome_ctrl (NSYN=32, N_SYM=255, FLUSH_CYC=2).
module tb_rs_syndrome_ctrl;

    logic       clock;
    logic       reset;
    logic       frame_start;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       synd_start;
    logic [7:0] synd_addr;
    logic [7:0] synd_root;
    logic       synd_root_valid;
    logic       synd_roots_done;
    logic [7:0] synd_data;
    logic       synd_new_data;
    logic       synd_stop;
    logic [7:0] synd_in;
    logic       synd_in_valid;
    logic [7:0] syn_out;
    logic [5:0] syn_out_idx;
    logic       syn_out_valid;
    logic       error_detected;
    logic       frame_done;
    logic       busy;
`ifdef RS_SYND_BYPASS_EN
    logic       bypass_en;
`endif

    int errors = 0;
    int checks = 0;

    // Hand-computed alpha^1..alpha^32 for x^8+x^4+x^3+x^2+1.
    logic [7:0] roots_exp [32] = '{
        8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D,
        8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C,
        8'h98, 8'h2D, 8'h5A, 8'hB4, 8'h75, 8'hEA, 8'hC9, 8'h8F,
        8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h9D
    };

    // Monitor records
    logic [7:0] ra [$];
    logic [7:0] rv [$];
    logic [7:0] nd [$];
    logic [5:0] si [$];
    logic [7:0] sv [$];
    int cyc = 0;
    int last_root_cyc = 0;
    int done_cyc = 0;
    int n_done = 0;
    int n_fd = 0;
    int stop_seen = 0;

    rs_syndrome_ctrl dut (
        .clock           (clock),
        .reset           (reset),
`ifdef RS_SYND_BYPASS_EN
        .bypass_en       (bypass_en),
`endif
        .frame_start     (frame_start),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .synd_start      (synd_start),
        .synd_addr       (synd_addr),
        .synd_root       (synd_root),
        .synd_root_valid (synd_root_valid),
        .synd_roots_done (synd_roots_done),
        .synd_data       (synd_data),
        .synd_new_data   (synd_new_data),
        .synd_stop       (synd_stop),
        .synd_in         (synd_in),
        .synd_in_valid   (synd_in_valid),
        .syn_out         (syn_out),
        .syn_out_idx     (syn_out_idx),
        .syn_out_valid   (syn_out_valid),
        .error_detected  (error_detected),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record DUT output beats on the falling edge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (synd_root_valid) begin
            ra.push_back(synd_addr);
            rv.push_back(synd_root);
            last_root_cyc <= cyc;
        end
        if (synd_roots_done) begin
            done_cyc <= cyc;
            n_done   <= n_done + 1;
        end
        if (synd_new_data) nd.push_back(synd_data);
        if (syn_out_valid) begin
            si.push_back(syn_out_idx);
            sv.push_back(syn_out);
        end
        if (frame_done) n_fd <= n_fd + 1;
        if (synd_stop) stop_seen <= stop_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_roots();
        int base;
        int w;
        base = n_done;
        w = 0;
        while (n_done == base && w < 100) begin
            @(negedge clock);
            w++;
        end
        chk("roots_done_seen", n_done - base, 1);
    endtask

    task automatic check_roots(input int rbase);
        chk("root_count", ra.size() - rbase, 32);
        for (int i = 0; i < 32 && rbase + i < ra.size(); i++) begin
            chk($sformatf("root_addr[%0d]", i), ra[rbase + i], i + 1);
            chk($sformatf("root_val[%0d]", i), rv[rbase + i], roots_exp[i]);
        end
        chk("roots_done_timing", done_cyc, last_root_cyc + 1);
    endtask

    // Feed n symbols (value index^xv); toggle gives a 1-0-1 valid pattern.
    task automatic stream(input int n, input bit toggle, input logic [7:0] xv, input int fs_at);
        int  sent;
        int  guard;
        bit  v;
        bit  fs_done;
        sent = 0;
        guard = 0;
        v = 1'b0;
        fs_done = 1'b0;
        while (sent < n && guard < 4000) begin
            @(negedge clock);
            v = toggle ? !v : 1'b1;
            in_valid = v;
            in_data = 8'(sent) ^ xv;
            if (sent == fs_at && !fs_done) begin
                frame_start = 1'b1;
                fs_done = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            if (v && in_ready) sent++;
            guard++;
        end
        @(negedge clock);
        in_valid = 1'b0;
        frame_start = 1'b0;
        chk("stream_accepts", sent, n);
    endtask

    task automatic check_symbols(input int nbase, input logic [7:0] xv);
        chk("symbol_count", nd.size() - nbase, 255);
        for (int i = 0; i < 255 && nbase + i < nd.size(); i++) begin
            chk($sformatf("symbol[%0d]", i), nd[nbase + i], 8'(i) ^ xv);
        end
    endtask

    // Calculator model: after the flush, return 32 syndromes (one optionally non-zero).
    task automatic collect(input int bad_idx, input logic [7:0] bad_val,
                           input bit exp_err, input bit fs_in_done);
        int sbase;
        int fdbase;
        int w;
        sbase = si.size();
        fdbase = n_fd;
        w = 0;
        while (!synd_stop && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("flush_len", w, 2);
        chk("synd_stop_high", synd_stop, 1'b1);
        chk("no_data_in_collect", synd_new_data, 1'b0);
        for (int i = 0; i < 32; i++) begin
            synd_in = (i + 1 == bad_idx) ? bad_val : 8'h00;
            synd_in_valid = 1'b1;
            @(negedge clock);
        end
        synd_in_valid = 1'b0;
        synd_in = 8'h00;
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("error_detected", error_detected, exp_err);
        chk("busy_in_done", busy, 1'b1);
        chk("stop_low_in_done", synd_stop, 1'b0);
        if (fs_in_done) frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("frame_done_cleared", frame_done, 1'b0);
        chk("idle_after_done", busy, 1'b0);
        chk("error_held", error_detected, exp_err);
        chk("no_roots_after_done", synd_root_valid, 1'b0);
        chk("in_ready_idle", in_ready, 1'b0);
        @(negedge clock);
        chk("syn_beats", si.size() - sbase, 32);
        for (int i = 0; i < 32 && sbase + i < si.size(); i++) begin
            chk($sformatf("syn_idx[%0d]", i), si[sbase + i], i + 1);
            chk($sformatf("syn_val[%0d]", i), sv[sbase + i], (i + 1 == bad_idx) ? bad_val : 8'h00);
        end
        chk("frame_done_count", n_fd - fdbase, 1);
        chk("still_idle", busy, 1'b0);
    endtask

    initial begin
        int rbase;
        int nbase;
        int fdbase;
        reset = 1'b0;
        frame_start = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        synd_in = 8'h00;
        synd_in_valid = 1'b0;
`ifdef RS_SYND_BYPASS_EN
        bypass_en = 1'b0;
`endif
        repeat (3) @(negedge clock);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_synd_start", synd_start, 1'b0);
        chk("rst_root_valid", synd_root_valid, 1'b0);
        chk("rst_synd_stop", synd_stop, 1'b0);
        chk("rst_syn_out_valid", syn_out_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error_detected, 1'b0);
        chk("rst_synd_root", synd_root, 8'h00);
        reset = 1'b1;
        @(negedge clock);

        // Syndrome beats while idle are ignored.
        synd_in = 8'h77;
        synd_in_valid = 1'b1;
        @(negedge clock);
        synd_in_valid = 1'b0;
        synd_in = 8'h00;
        @(negedge clock);
        chk("idle_synd_ignored", syn_out_valid, 1'b0);
        chk("idle_synd_no_start", busy, 1'b0);

        // Frame 1: root load, continuous stream, all-zero syndromes.
        rbase = ra.size();
        nbase = nd.size();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("f1_synd_start", synd_start, 1'b1);
        chk("f1_first_root_valid", synd_root_valid, 1'b1);
        chk("f1_first_addr", synd_addr, 8'd1);
        chk("f1_busy", busy, 1'b1);
        chk("f1_in_ready_during_load", in_ready, 1'b0);
        wait_roots();
        check_roots(rbase);
        stream(255, 1'b0, 8'h00, -1);
        chk("f1_in_ready_low", in_ready, 1'b0);
        collect(0, 8'h00, 1'b0, 1'b0);
        check_symbols(nbase, 8'h00);

        // Frame 2: roots already loaded, 1-0-1 valid, stray frame_start, error at idx 7.
        rbase = ra.size();
        nbase = nd.size();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("f2_in_ready_next", in_ready, 1'b1);
        chk("f2_no_root_valid", synd_root_valid, 1'b0);
        chk("f2_no_synd_start", synd_start, 1'b0);
        stream(255, 1'b1, 8'hA5, 50);
        chk("f2_in_ready_low", in_ready, 1'b0);
        collect(7, 8'h5A, 1'b1, 1'b1);
        check_symbols(nbase, 8'hA5);
        chk("f2_no_root_writes", ra.size() - rbase, 0);

        // Frame 3: reset in the middle of streaming.
        fdbase = n_fd;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        stream(100, 1'b0, 8'h3C, -1);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_new_data", synd_new_data, 1'b0);
        chk("mid_rst_synd_data", synd_data, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_stop", synd_stop, 1'b0);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        chk("mid_rst_error", error_detected, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_no_frame_done", n_fd - fdbase, 0);

        // Frame 4: roots reload after reset; error on the final syndrome.
        rbase = ra.size();
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk("f4_reload_root_valid", synd_root_valid, 1'b1);
        wait_roots();
        check_roots(rbase);
        stream(255, 1'b0, 8'h81, -1);
        collect(32, 8'h01, 1'b1, 1'b0);

`ifdef RS_SYND_BYPASS_EN
        // Bypass frame: symbols streamed, no collection, done right after last symbol.
        begin
            int stop_base;
            int sbase;
            stop_base = stop_seen;
            sbase = si.size();
            nbase = nd.size();
            bypass_en = 1'b1;
            frame_start = 1'b1;
            @(negedge clock);
            frame_start = 1'b0;
            bypass_en = 1'b0;
            stream(255, 1'b0, 8'h00, -1);
            chk("byp_frame_done", frame_done, 1'b1);
            chk("byp_error", error_detected, 1'b0);
            chk("byp_no_stop", synd_stop, 1'b0);
            @(negedge clock);
            @(negedge clock);
            chk("byp_stop_never", stop_seen - stop_base, 0);
            chk("byp_no_syn_beats", si.size() - sbase, 0);
            chk("byp_idle", busy, 1'b0);
            check_symbols(nbase, 8'h00);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_ctrl.md
Name: rs_syndrome_ctrl

Overview:
- Sequencer for the Reed-Solomon syndrome calculator. It loads the NSYN generator roots (alpha^1..alpha^NSYN) into the calculator's root table once after reset.
- For each codeword it streams N_SYM received symbols from an upstream valid/ready source into the calculator, then drains the NSYN syndromes to the downstream key-equation solver.
- It flags an error when any syndrome is non-zero.

Parameters:
- NSYN, 32, number of syndromes/roots (2..32).
- N_SYM, 255, symbols per codeword (NSYN+1..255).
- PRIM_POLY, 8'h1D, low byte of the GF(2^8) primitive polynomial x^8+x^4+x^3+x^2+1.
- FLUSH_CYC, 2, idle cycles between last symbol and syndrome collection (covers calculator pipeline).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse: begin a codeword.
- in_data  in  8  received symbol.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts symbol.
- synd_start  out  1  root-load phase active (calculator start_syndrome).
- synd_addr  out  8  root table address, 1..NSYN.
- synd_root  out  8  root value for synd_addr.
- synd_root_valid  out  1  synd_addr/synd_root valid this cycle.
- synd_roots_done  out  1  one-cycle pulse after last root written.
- synd_data  out  8  symbol to calculator.
- synd_new_data  out  1  synd_data valid this cycle.
- synd_stop  out  1  collection phase active (calculator stop_syndrome).
- synd_in  in  8  syndrome value from calculator.
- synd_in_valid  in  1  synd_in valid.
- syn_out  out  8  syndrome to downstream.
- syn_out_idx  out  6  syndrome index, 1..NSYN.
- syn_out_valid  out  1  syn_out/syn_out_idx valid.
- error_detected  out  1  any syndrome non-zero; valid with frame_done.
- frame_done  out  1  one-cycle pulse, codeword complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs are 0.
  - State returns to IDLE.
  - roots_loaded flag, symbol counter, index counter and error accumulator are cleared.
  - Reset in any state aborts the frame with no frame_done, and forces a root reload on the next frame.
- IDLE:
  - A frame_start pulse goes to LOAD_ROOTS if roots_loaded=0, otherwise to STREAM.
  - frame_start in any other state is ignored (no queueing).
- LOAD_ROOTS:
  - synd_start=1.
  - For NSYN consecutive cycles synd_root_valid=1, with synd_addr=k and synd_root=alpha^k for k=1..NSYN.
  - alpha^1=8'h02. Next root is xtime(r) = {r[6:0],1'b0} ^ (r[7] ? PRIM_POLY : 0).
  - The cycle after the last root: synd_roots_done pulses, roots_loaded is set, state goes to STREAM.
- STREAM:
  - in_ready=1.
  - On each in_valid&in_ready, synd_data<=in_data and synd_new_data<=1 (registered, one-cycle latency). synd_new_data=0 on cycles with no accept.
  - in_valid low stalls without counter change.
  - The 8-bit symbol counter counts accepts 0..N_SYM-1. On accept of symbol N_SYM-1, in_ready deasserts the next cycle and state goes to FLUSH.
- FLUSH:
  - Holds for FLUSH_CYC cycles with in_ready=0 and synd_new_data=0 (after the final registered beat), then goes to COLLECT.
- COLLECT:
  - synd_stop=1.
  - Each synd_in_valid beat is forwarded registered:
    - syn_out<=synd_in, syn_out_idx<=index, syn_out_valid<=1, index starting at 1.
    - The error accumulator ORs (synd_in!=0).
  - After NSYN beats, state goes to DONE. synd_in_valid while not in COLLECT is ignored.
- DONE:
  - Lasts one cycle: frame_done=1, error_detected=accumulator (held until next frame_start).
  - Then IDLE. The accumulator clears on leaving IDLE.
- Latency:
  - Minimum frame (roots already loaded) = 1 + N_SYM + FLUSH_CYC + NSYN + 1 cycles from frame_start with no stalls.

Optional Feature:
- RS_SYND_BYPASS_EN: adds input port bypass_en, sampled on frame_start.
- With the macro, if bypass_en=1 the frame skips FLUSH/COLLECT:
  - After the last symbol goes directly to DONE.
  - error_detected=0, no syn_out beats.
  - Symbols are still streamed (calculator state stays consistent).
- Without the macro the port does not exist and every frame collects syndromes.

Decomposition:
- Shared package rs_pkg:
  - GF_W=8, PRIM_POLY constant, NSYN_MAX=32.
  - State enum {IDLE, LOAD_ROOTS, STREAM, FLUSH, COLLECT, DONE}.
  - Function gf_xtime.
- One sub-module, rs_root_gen: an alpha-power generator with load/step inputs, producing successive alpha^k. It is reused by the Chien search block.

Test Plan:
- Reset, frame_start, NSYN=32 → 32 root writes, addr 1..32; roots 8'h02, 8'h04, …, addr 8 = 8'h1D, addr 9 = 8'h3A; synd_roots_done one cycle after addr 32.
- Second frame_start → no root writes; in_ready high the cycle after frame_start.
- 255 symbols, in_valid toggled 1-0-1 → exactly 255 synd_new_data pulses, data order preserved, in_ready low after the 255th.
- Calculator model returns all-zero syndromes → syn_out_idx 1..32 in order, frame_done pulse, error_detected=0. One syndrome 8'h5A at idx 7 → error_detected=1.
- reset asserted mid-STREAM (symbol 100) → all outputs 0 immediately; next frame reloads roots.
- frame_start pulses during STREAM and in the DONE cycle → ignored; with RS_SYND_BYPASS_EN and bypass_en=1 → no synd_stop, frame_done right after the last symbol.
